// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stall vectors, exception codes and FSM encodings.
package pipe_ctrl_pkg;

  localparam logic        STOP      = 1'b1;
  localparam logic        NO_STOP   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Stall vector bit order: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [0:0] PCTRL_IDLE  = 1'b0;
  localparam logic [0:0] PCTRL_DRAIN = 1'b1;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-facing bundle of pipe_ctrl: stall requests and exception inputs, stall/flush/redirect outputs.
interface pipe_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc
  );
endinterface

// File: rtl/pipe_ctrl_wdog.sv
// Consecutive-stall watchdog: counts held cycles and raises a sticky timeout flag on expiry.
module pipe_ctrl_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,      // a stall request is present while in IDLE
  input  logic cnt_en_i,   // the pipeline is actually held this cycle
  input  logic wdog_clr_i,
  output logic fire_o,
  output logic timeout_o
);

  localparam logic [15:0] FIRE_AT = 16'(WDOG_LIMIT - 1);

  logic [15:0] cnt;

  assign fire_o = req_i && (cnt == FIRE_AT);

  // A fire always flushes, so cnt_en_i is low that cycle and the count restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_en_i) begin
      cnt <= cnt + 16'd1;
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_o <= NO_STOP;
    end else if (fire_o) begin
      timeout_o <= 1'b1;
    end else if (wdog_clr_i) begin
      timeout_o <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall arbitration, exception/ERET flush FSM and stall watchdog.
// Optional perf counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned WDOG_LIMIT   = 1024
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   pif,
  input  logic         wdog_clr_i,
  output logic         timeout_o,
  output logic         busy_o,
  output logic [31:0]  stall_cycles_o,
  output logic [15:0]  flush_count_o
);

  localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_CYCLES - 1);

  logic [0:0]  state;
  logic [3:0]  drain_cnt;
  logic [31:0] target_q;
  logic [31:0] exc_target;
  logic [5:0]  arb_stall;
  logic        wdog_fire;
  logic        exc_pending;
  logic        take_flush;

  always_comb begin
    if (pif.stallreq_from_mem)     arb_stall = STALL_MEM;
    else if (pif.stallreq_from_ex) arb_stall = STALL_EX;
    else if (pif.stallreq_from_id) arb_stall = STALL_ID;
    else if (pif.stallreq_from_if) arb_stall = STALL_IF;
    else                           arb_stall = STALL_NONE;
  end

  assign exc_pending = (pif.excepttype_i != ZERO_WORD) || wdog_fire;

  always_comb begin
    if (wdog_fire)                        exc_target = EXC_VECTOR;
    else if (pif.excepttype_i == EXC_ERET) exc_target = pif.cp0_epc_i;
    else                                  exc_target = EXC_VECTOR;
  end

  // Outputs are gated by rst so an asserted reset silences the pipeline without a clock edge.
  always_comb begin
    pif.stall  = STALL_NONE;
    pif.flush  = 1'b0;
    pif.new_pc = target_q;
    busy_o     = 1'b0;
    take_flush = 1'b0;
    if (rst) begin
      pif.new_pc = ZERO_WORD;
    end else if (state == PCTRL_DRAIN) begin
      pif.flush = 1'b1;
      busy_o    = 1'b1;
    end else if (exc_pending && (!pif.stallreq_from_mem || wdog_fire)) begin
      pif.flush  = 1'b1;
      pif.new_pc = exc_target;
      take_flush = 1'b1;
    end else if (exc_pending) begin
      pif.stall = STALL_MEM;
    end else begin
      pif.stall = arb_stall;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PCTRL_IDLE;
      drain_cnt <= '0;
      target_q  <= ZERO_WORD;
    end else if (state == PCTRL_IDLE) begin
      if (take_flush) begin
        target_q <= exc_target;
        if (FLUSH_CYCLES > 1) begin
          state     <= PCTRL_DRAIN;
          drain_cnt <= DRAIN_INIT;
        end
      end
    end else begin
      if (drain_cnt == 4'd1) state <= PCTRL_IDLE;
      drain_cnt <= drain_cnt - 4'd1;
    end
  end

  pipe_ctrl_wdog #(
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk        (clk),
    .rst        (rst),
    .req_i      ((state == PCTRL_IDLE) && (arb_stall != STALL_NONE)),
    .cnt_en_i   (pif.stall != STALL_NONE),
    .wdog_clr_i (wdog_clr_i),
    .fire_o     (wdog_fire),
    .timeout_o  (timeout_o)
  );

`ifdef PIPE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if ((pif.stall != STALL_NONE) && (stall_cycles_o != '1))
        stall_cycles_o <= stall_cycles_o + 32'd1;
      // One count per flush event; drain cycles do not re-trigger take_flush.
      if (take_flush && (flush_count_o != '1))
        flush_count_o <= flush_count_o + 16'd1;
    end
  end
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two configurations share stimulus, a reference model predicts each cycle.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        to;
    logic [31:0] sc;
    logic [15:0] fc;
  } exp_t;

  localparam logic [31:0] EXC = 32'h0000_0020;
  localparam int FC[2] = '{1, 3};
  localparam int WL[2] = '{16, 8};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wdog_clr = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if ia ();
  pipe_ctrl_if ib ();

  logic        to_a, to_b, busy_a, busy_b;
  logic [31:0] sc_a, sc_b;
  logic [15:0] fc_a, fc_b;

  pipe_ctrl #(.FLUSH_CYCLES(1), .EXC_VECTOR(EXC), .WDOG_LIMIT(16)) dut_a (
    .clk(clk), .rst(rst), .pif(ia), .wdog_clr_i(wdog_clr), .timeout_o(to_a),
    .busy_o(busy_a), .stall_cycles_o(sc_a), .flush_count_o(fc_a));

  pipe_ctrl #(.FLUSH_CYCLES(3), .EXC_VECTOR(EXC), .WDOG_LIMIT(8)) dut_b (
    .clk(clk), .rst(rst), .pif(ib), .wdog_clr_i(wdog_clr), .timeout_o(to_b),
    .busy_o(busy_b), .stall_cycles_o(sc_b), .flush_count_o(fc_b));

  exp_t q[2][$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model state: remaining drain cycles, held target, consecutive-stall count, sticky flag, perf counters.
  int          m_dl[2];
  logic [31:0] m_tgt[2];
  int          m_wc[2];
  logic        m_to[2];
  logic [31:0] m_sc[2];
  logic [15:0] m_fc[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_dl[d] = 0; m_tgt[d] = '0; m_wc[d] = 0; m_to[d] = 1'b0; m_sc[d] = '0; m_fc[d] = '0;
    end
  endtask

  // req = {mem, ex, id, if}
  task automatic drive(input bit r, input bit [3:0] req, input logic [31:0] et,
                       input logic [31:0] epc, input bit clr);
    exp_t e;
    logic [5:0] arb;
    bit fire;
    @(posedge clk);
    #1;
    rst = r;
    wdog_clr = clr;
    ia.stallreq_from_if = req[0]; ib.stallreq_from_if = req[0];
    ia.stallreq_from_id = req[1]; ib.stallreq_from_id = req[1];
    ia.stallreq_from_ex = req[2]; ib.stallreq_from_ex = req[2];
    ia.stallreq_from_mem = req[3]; ib.stallreq_from_mem = req[3];
    ia.excepttype_i = et; ib.excepttype_i = et;
    ia.cp0_epc_i = epc;   ib.cp0_epc_i = epc;
    if (r) model_reset();
    for (int d = 0; d < 2; d++) begin
      e = '0;
      fire = 1'b0;
      if (!r) begin
        e.to = m_to[d];
        e.sc = m_sc[d];
        e.fc = m_fc[d];
        if (m_dl[d] > 0) begin
          e.flush = 1'b1; e.pc = m_tgt[d]; e.busy = 1'b1;
          m_dl[d]--; m_wc[d] = 0;
        end else begin
          arb = req[3] ? 6'b011111 : req[2] ? 6'b001111 : req[1] ? 6'b000111 :
                req[0] ? 6'b000011 : 6'b000000;
          fire = (arb != 0) && (m_wc[d] == WL[d] - 1);
          if (fire || (et != 0 && !req[3])) begin
            e.flush = 1'b1;
            e.pc = fire ? EXC : (et == 32'he ? epc : EXC);
            m_tgt[d] = e.pc;
            m_dl[d] = FC[d] - 1;
            m_wc[d] = 0;
            if (m_fc[d] != 16'hFFFF) m_fc[d]++;
          end else begin
            e.stall = (et != 0) ? 6'b011111 : arb;
            m_wc[d] = (e.stall != 0) ? m_wc[d] + 1 : 0;
            if (m_sc[d] != 32'hFFFF_FFFF) m_sc[d]++;
            if (e.stall == 0) m_sc[d]--;
          end
        end
        m_to[d] = fire ? 1'b1 : (clr ? 1'b0 : m_to[d]);
      end
`ifndef PIPE_CTRL_PERF_CNT_EN
      e.sc = '0;
      e.fc = '0;
`endif
      q[d].push_back(e);
    end
  endtask

  task automatic check(input int d, input exp_t e, input exp_t a);
    n_vec++;
    if (a.stall !== e.stall) begin
      n_bad++; $display("FAIL dut%0d stall: got %b want %b at %0t", d, a.stall, e.stall, $time);
    end
    if (a.flush !== e.flush) begin
      n_bad++; $display("FAIL dut%0d flush: got %b want %b at %0t", d, a.flush, e.flush, $time);
    end
    if (e.flush && a.pc !== e.pc) begin
      n_bad++; $display("FAIL dut%0d new_pc: got %h want %h at %0t", d, a.pc, e.pc, $time);
    end
    if (a.busy !== e.busy) begin
      n_bad++; $display("FAIL dut%0d busy_o: got %b want %b at %0t", d, a.busy, e.busy, $time);
    end
    if (a.to !== e.to) begin
      n_bad++; $display("FAIL dut%0d timeout_o: got %b want %b at %0t", d, a.to, e.to, $time);
    end
    if (a.sc !== e.sc) begin
      n_bad++; $display("FAIL dut%0d stall_cycles_o: got %0d want %0d at %0t", d, a.sc, e.sc, $time);
    end
    if (a.fc !== e.fc) begin
      n_bad++; $display("FAIL dut%0d flush_count_o: got %0d want %0d at %0t", d, a.fc, e.fc, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per configuration.
  initial begin
    forever begin
      @(negedge clk);
      if (q[0].size() > 0)
        check(0, q[0].pop_front(), {ia.stall, ia.flush, ia.new_pc, busy_a, to_a, sc_a, fc_a});
      if (q[1].size() > 0)
        check(1, q[1].pop_front(), {ib.stall, ib.flush, ib.new_pc, busy_b, to_b, sc_b, fc_b});
    end
  end

  initial begin
    bit [3:0]    req;
    logic [31:0] et;
    int          pick;
    model_reset();
    rst = 1'b1;
    ia.stallreq_from_if = 0; ia.stallreq_from_id = 0; ia.stallreq_from_ex = 0; ia.stallreq_from_mem = 0;
    ib.stallreq_from_if = 0; ib.stallreq_from_id = 0; ib.stallreq_from_ex = 0; ib.stallreq_from_mem = 0;
    ia.excepttype_i = '0; ib.excepttype_i = '0; ia.cp0_epc_i = '0; ib.cp0_epc_i = '0;

    repeat (3) drive(1, 4'b0000, '0, '0, 0);
    // id+ex together, then release
    repeat (3) drive(0, 4'b0110, '0, '0, 0);
    repeat (2) drive(0, 4'b0000, '0, '0, 0);
    // plain exception, then ERET
    drive(0, 4'b0000, 32'h8, '0, 0);
    repeat (3) drive(0, 4'b0000, '0, '0, 0);
    drive(0, 4'b0000, 32'he, 32'h0040_0104, 0);
    repeat (4) drive(0, 4'b0000, '0, '0, 0);
    // exception held off by a mem stall for 4 cycles
    repeat (4) drive(0, 4'b1000, 32'hc, '0, 0);
    drive(0, 4'b0000, 32'hc, '0, 0);
    repeat (4) drive(0, 4'b0000, '0, '0, 0);
    // watchdog on IF stall, then clear
    repeat (20) drive(0, 4'b0001, '0, '0, 0);
    repeat (2) drive(0, 4'b0000, '0, '0, 0);
    drive(0, 4'b0000, '0, '0, 1);
    repeat (2) drive(0, 4'b0000, '0, '0, 0);
    // watchdog during a mem stall with an exception pending
    repeat (20) drive(0, 4'b1000, 32'hc, '0, 0);
    drive(0, 4'b0000, '0, '0, 1);
    // ERET coinciding with watchdog fire; clear held high through the fire
    repeat (7) drive(0, 4'b0001, '0, '0, 1);
    drive(0, 4'b0001, 32'he, 32'h1234_5678, 1);
    repeat (4) drive(0, 4'b0000, '0, '0, 0);
    // reset in the middle of a drain window, with inputs still active
    drive(0, 4'b0000, 32'h8, '0, 0);
    drive(1, 4'b1011, 32'h8, 32'h55, 0);
    drive(1, 4'b0000, '0, '0, 0);
    repeat (2) drive(0, 4'b0000, '0, '0, 0);

    for (int i = 0; i < 2000; i++) begin
      req[3] = ($urandom_range(0, 5) == 0);
      req[2] = ($urandom_range(0, 4) == 0);
      req[1] = ($urandom_range(0, 4) == 0);
      req[0] = ($urandom_range(0, 2) == 0);
      et = '0;
      if ($urandom_range(0, 11) == 0) begin
        pick = $urandom_range(0, 3);
        et = (pick == 0) ? 32'h8 : (pick == 1) ? 32'hc : (pick == 2) ? 32'he : ($urandom() | 32'h1);
      end
      drive(($urandom_range(0, 499) == 0), req, et, $urandom(), ($urandom_range(0, 19) == 0));
    end

    for (int i = 0; i < 5 && (q[0].size() > 0 || q[1].size() > 0); i++) @(negedge clk);
    #1;
    if (q[0].size() > 0 || q[1].size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d/%0d expectations left, want 0", q[0].size(), q[1].size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It arbitrates stall requests from IF, ID, EX and MEM into the 6-bit stall vector consumed by pc_reg and every inter-stage register. It sequences exception and ERET flushes through a small FSM that holds flush for a programmable drain window. A consecutive-stall watchdog forces recovery when a stage hangs.

Parameters:
FLUSH_CYCLES, 1, cycles flush_o stays high per flush event (1..15)
EXC_VECTOR, 32'h00000020, handler address for all non-ERET exceptions and watchdog timeout
WDOG_LIMIT, 1024, consecutive stalled cycles that trigger timeout (2..65535)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stallreq_from_if  in  1  instruction bus wait
stallreq_from_id  in  1  load-use hazard stall
stallreq_from_ex  in  1  multi-cycle mul/div/madd stall
stallreq_from_mem  in  1  data bus wait
excepttype_i  in  32  final exception type from MEM stage; 0 = none
cp0_epc_i  in  32  EPC value, forwarding already applied
wdog_clr_i  in  1  clears sticky timeout flag
stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1 = hold
flush  out  1  clear all inter-stage registers, PC loads new_pc
new_pc  out  32  redirect target, valid while flush=1
timeout_o  out  1  sticky watchdog-fired flag
busy_o  out  1  FSM not in IDLE
stall_cycles_o  out  32  perf: stalled-cycle count
flush_count_o  out  16  perf: flush events

Behaviour:
- Reset (async): FSM=IDLE, drain counter=0, wdog counter=0, new_pc register=0, timeout_o=0. Outputs: stall=6'b000000, flush=0, new_pc=0, busy_o=0, perf counters=0.
- Stall arbitration is combinational in IDLE. Priority is mem > ex > id > if: mem gives 6'b011111, ex gives 6'b001111, id gives 6'b000111, if gives 6'b000011, none gives 6'b000000.
- Exception target decode: excepttype_i==32'h0000000e (ERET) gives cp0_epc_i; any other nonzero value gives EXC_VECTOR.
- IDLE, exception pending (excepttype_i!=0 or wdog fire):
  - With stallreq_from_mem=1: no flush; stall=6'b011111. The exception is re-sampled next cycle because the MEM stage is held.
  - With stallreq_from_mem=0: flush=1 and new_pc=target in the same cycle (zero latency), stall=0. The target is registered.
  - If FLUSH_CYCLES>1, go to DRAIN with counter=FLUSH_CYCLES-1; otherwise stay in IDLE.
- DRAIN: flush=1, new_pc=registered target, stall=0. All requests and excepttype_i are ignored. The counter decrements each cycle; at counter==1 the next state is IDLE.
- A flush beats every stall request except mem. Simultaneous ERET and watchdog fire: the watchdog wins and the target is EXC_VECTOR.
- Watchdog:
  - Counts cycles in IDLE with stall!=0. It clears on any cycle with stall==0 or on flush.
  - When the count reaches WDOG_LIMIT-1 and the stall persists, it fires. That sets timeout_o and takes the exception path.
  - It fires even during a mem stall: it overrides the mem hold and flushes immediately.
- timeout_o is sticky until wdog_clr_i=1. If wdog_clr_i=1 in the same cycle as a fire, the set wins.
- busy_o=1 in DRAIN only.
- Reset mid-DRAIN: immediate IDLE, flush drops asynchronously.

Optional Feature:
- Macro PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - stall_cycles_o increments on every cycle with stall!=0 and saturates at 32'hFFFFFFFF.
  - flush_count_o increments once per flush event (not per drain cycle) and saturates at 16'hFFFF.
  - Both counters clear on rst only.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised.

Decomposition:
- The following go in the shared defines header:
  - stall vector constants STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM.
  - ERET exception code 32'h0000000e.
  - Reuse of the existing Stop/NoStop and ZeroWord macros.
  - FSM state encodings PCTRL_IDLE and PCTRL_DRAIN.
- One sub-module, pipe_ctrl_wdog: the consecutive-stall counter plus sticky flag, so it can be verified standalone.

Test Plan:
- stallreq_from_id=1 and stallreq_from_ex=1 together -> stall=6'b001111, flush=0; release both -> 6'b000000 next cycle.
- excepttype_i=32'h00000008, no stalls, FLUSH_CYCLES=1 -> same cycle flush=1, new_pc=32'h00000020; next cycle flush=0, flush_count_o=1.
- excepttype_i=32'h0000000e, cp0_epc_i=32'h00400104, FLUSH_CYCLES=3 -> flush high exactly 3 cycles with new_pc=32'h00400104; busy_o high for cycles 2-3.
- excepttype_i=32'h0000000c with stallreq_from_mem=1 for 4 cycles -> stall=6'b011111, flush=0 for 4 cycles; flush=1 in cycle 5.
- WDOG_LIMIT=8, stallreq_from_if held high -> flush=1, new_pc=EXC_VECTOR on the 8th stalled cycle; timeout_o=1 until wdog_clr_i pulses.
- rst asserted mid-DRAIN -> flush=0, stall=0, busy_o=0 without waiting for a clock edge; perf counters=0.
